// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between three masters; read data is returned with a one-hot valid tag.
// Latency: grant is combinational in the request cycle; rvalid follows the grant by RD_LAT cycles. Backpressure: a master holds req until gnt; reads never stall.
// Optional `MEM_ARB_LOCK_EN adds a per-master lock input that lets the current owner keep the port for bursts.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [2:0]            lock,
`endif
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
);

    logic [1:0]        r_last;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_din_q;
    logic [2:0]        r_tag [RD_LAT];

    logic              w_any;
    logic [1:0]        w_sel;
    logic [1:0]        w_cand;
    logic [2:0]        w_tag_in;

`ifdef MEM_ARB_LOCK_EN
    logic              r_lock_vld;
    logic [1:0]        r_lock_own;
`endif

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search starts one past the last winner; the first requester found wins.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = 2'd0;
        w_cand = rr_next(r_last);
        for (int k = 0; k < 3; k++) begin
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
            w_cand = rr_next(w_cand);
        end
`ifdef MEM_ARB_LOCK_EN
        if (r_lock_vld && req[r_lock_own] && lock[r_lock_own]) begin
            w_any = 1'b1;
            w_sel = r_lock_own;
        end
`endif
        if (!rst_n) begin
            w_any = 1'b0;
        end
    end

    // Idle cycles replay the last address/data so the RAM pins stay quiet.
    always_comb begin
        gnt      = w_any ? (3'b001 << w_sel) : 3'b000;
        ram_en   = w_any;
        ram_we   = w_any & we[w_sel];
        ram_addr = w_any ? addr[w_sel*ADDR_W +: ADDR_W]  : r_addr_q;
        ram_din  = w_any ? wdata[w_sel*DATA_W +: DATA_W] : r_din_q;
        w_tag_in = gnt & {3{~ram_we}};
        rvalid   = r_tag[RD_LAT-1];
        rdata    = ram_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 2'd2;
            r_addr_q <= '0;
            r_din_q  <= '0;
        end else if (w_any) begin
            r_last   <= w_sel;
            r_addr_q <= ram_addr;
            r_din_q  <= ram_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= 3'b000;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

`ifdef MEM_ARB_LOCK_EN
    // Lock survives only while the owner keeps both req and lock high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_vld <= 1'b0;
            r_lock_own <= 2'd0;
        end else begin
            r_lock_vld <= w_any & lock[w_sel];
            r_lock_own <= w_sel;
        end
    end
`endif

endmodule
